// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared constants and one-hot FSM encodings for the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam logic [7:0] c_loader_magic = 8'hA5;

    // One-hot, 7 bits, in line with the core's one-hot stage style
    typedef enum logic [6:0] {
        c_st_idle   = 7'b000_0001,
        c_st_len_lo = 7'b000_0010,
        c_st_len_hi = 7'b000_0100,
        c_st_data   = 7'b000_1000,
        c_st_csum   = 7'b001_0000,
        c_st_done   = 7'b010_0000,
        c_st_error  = 7'b100_0000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_word_packer
// Description : Assembles 4 LSB-first bytes into a 32-bit word, one-cycle ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_last,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx        <= 2'd0;
            r_shift      <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clr) begin
                r_idx   <= 2'd0;
                r_shift <= 24'd0;
            end else if (i_valid) begin
                // Bytes enter at the top, so after three the shifter holds {b2,b1,b0}
                if (r_idx == 2'd3) begin
                    r_word       <= {i_byte, r_shift};
                    r_word_valid <= 1'b1;
                    r_idx        <= 2'd0;
                end else begin
                    r_shift <= {i_byte, r_shift[23:8]};
                    r_idx   <= r_idx + 2'd1;
                end
            end
        end
    end

    assign o_last       = (r_idx == 2'd3);
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Parses a framed byte stream and writes the program memory; holds the core until a good frame lands.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] MAGIC  = c_loader_magic
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] c_max_words = 17'(2 ** ADDR_W);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [15:0]       r_wcnt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_xor;

    logic [15:0]       w_len;
    logic              w_len_big;
    logic              w_data_byte;
    logic              w_byte_last;
    logic              w_last_word;
    logic              w_pkr_clr;

    assign w_len       = {rx_data, r_len_lo};
    assign w_len_big   = ({1'b0, w_len} > c_max_words);
    assign w_data_byte = rx_valid && (r_state == c_st_data);
    assign w_last_word = (r_wcnt == (r_len - 16'd1));
    assign w_pkr_clr   = rx_valid && (r_state == c_st_len_hi);

    prog_loader_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_pkr_clr),
        .i_valid      (w_data_byte),
        .i_byte       (rx_data),
        .o_last       (w_byte_last),
        .o_word_valid (mem_we),
        .o_word       (mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (rx_valid) begin
            case (r_state)
                c_st_idle:   if (rx_data == MAGIC) w_next = c_st_len_lo;
                c_st_len_lo: w_next = c_st_len_hi;
                c_st_len_hi: begin
                    if (w_len == 16'd0)  w_next = c_st_csum;
                    else if (w_len_big)  w_next = c_st_error;
                    else                 w_next = c_st_data;
                end
                c_st_data:   if (w_byte_last && w_last_word) w_next = c_st_csum;
                c_st_csum:   w_next = (rx_data == r_xor) ? c_st_done : c_st_error;
                c_st_done,
                c_st_error:  if (rx_data == MAGIC) w_next = c_st_len_lo;
                default:     w_next = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_wcnt     <= 16'd0;
            r_waddr    <= '0;
            r_mem_addr <= '0;
            r_xor      <= 8'd0;
        end else begin
            if (rx_valid && (r_state == c_st_len_lo)) begin
                r_len_lo <= rx_data;
            end
            if (rx_valid && (r_state == c_st_len_hi)) begin
                r_len   <= w_len;
                r_wcnt  <= 16'd0;
                r_waddr <= '0;
                r_xor   <= 8'd0;
            end
            if (w_data_byte) begin
                r_xor <= r_xor ^ rx_data;
                // Address is captured alongside the packer's word so both land together
                if (w_byte_last) begin
                    r_mem_addr <= r_waddr;
                    r_waddr    <= r_waddr + ADDR_W'(1);
                    r_wcnt     <= r_wcnt + 16'd1;
                end
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign cpu_hold = (r_state != c_st_done);
    assign done     = (r_state == c_st_done);
    assign err      = (r_state == c_st_error);

endmodule
`default_nettype wire
